// File: rtl/usr_pkg.sv
// Shared encodings for the USR command sequencer: USR MODE values, FSM states, default sizes.
// READ reuses the MODE_HOLD code, so cmd_op and usr_mode share one encoding.
package usr_pkg;

    localparam int USR_WIDTH = 4;
    localparam int USR_CNT_W = 3;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/usr_ctrl.sv
// Sequences one LOAD/SHR/SHL/READ command into USR MODE/DATAIN pins, then samples DATAOUT.
// Response 2+N cycles after accept (N mode cycles); one command at a time, no response backpressure.
module usr_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH,
    parameter int CNT_W = USR_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_datain,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);

    state_t           state;
    state_t           state_d;
    logic [1:0]       mode_d;
    logic [WIDTH-1:0] datain_d;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic [WIDTH-1:0] fill_word;

    // The USR takes its serial-in bit from DATAIN[0].
    assign fill_word = {{(WIDTH-1){1'b0}}, cmd_fill};

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_d     = state;
        mode_d      = usr_mode;
        datain_d    = usr_datain;
        rem_d       = rem;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == MODE_LOAD) begin
                        mode_d   = MODE_LOAD;
                        datain_d = cmd_data;
                        rem_d    = '0;
                        state_d  = ST_RUN;
                    end else if (cmd_op != MODE_HOLD && cmd_count != '0) begin
                        mode_d   = cmd_op;
                        datain_d = fill_word;
                        rem_d    = cmd_count - CNT_W'(1);
                        state_d  = ST_RUN;
                    end else begin
                        // READ and zero-count shifts never touch the USR.
                        state_d  = ST_CAPTURE;
                    end
                end
            end

            ST_RUN: begin
                if (rem == '0) begin
                    mode_d   = MODE_HOLD;
                    datain_d = '0;
                    state_d  = ST_CAPTURE;
                end else begin
                    rem_d    = rem - CNT_W'(1);
                end
            end

            ST_CAPTURE: begin
                rsp_data_d  = usr_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                mode_d   = MODE_HOLD;
                datain_d = '0;
                rem_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            usr_mode   <= MODE_HOLD;
            usr_datain <= '0;
            rem        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_d;
            usr_mode   <= mode_d;
            usr_datain <= datain_d;
            rem        <= rem_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_usr_ctrl.sv
// Bench for usr_ctrl wired to a behavioural 4-bit universal shift register.
module tb_usr_ctrl;
    import usr_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic       cmd_fill = 1'b0;
    logic [2:0] cmd_count = 3'd0;
    logic [1:0] usr_mode;
    logic [3:0] usr_datain;
    logic [3:0] usr_q;
    logic       busy;
    logic       rsp_valid;
    logic [3:0] rsp_data;

    usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_fill(cmd_fill), .cmd_count(cmd_count),
        .usr_mode(usr_mode), .usr_datain(usr_datain), .usr_q(usr_q),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clock = ~clock;

    // Universal shift register: SHR fills the MSB, SHL fills the LSB, serial bit on DATAIN[0].
    always @(posedge clock) begin
        if (reset) usr_q <= 4'h0;
        else case (usr_mode)
            MODE_SHR:  usr_q <= {usr_datain[0], usr_q[3:1]};
            MODE_SHL:  usr_q <= {usr_q[2:0], usr_datain[0]};
            MODE_LOAD: usr_q <= usr_datain;
            default:   usr_q <= usr_q;
        endcase
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic       fill;
        logic [2:0] cnt;
        int         n;
        logic [3:0] rsp;
    } vec_t;

    vec_t       vt [11];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_mode, n_busy, rsp_k;
    logic [3:0] rsp_d;
    logic       side_ok, ready_at_rsp, valid_after;
    logic [3:0] tr [0:41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one command from a negedge in IDLE; returns at the negedge after the response pulse.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic fill,
                           input logic [2:0] cnt);
        logic [3:0] edin;
        edin = (op == MODE_LOAD) ? data : {3'b000, fill};
        n_mode = 0; n_busy = 0; rsp_k = -1; rsp_d = 4'h0;
        side_ok = 1'b1; ready_at_rsp = 1'b0; valid_after = 1'b1;
        cmd_op = op; cmd_data = data; cmd_fill = fill; cmd_count = cnt; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tr[k] = usr_q;
            if (usr_mode !== MODE_HOLD) begin
                n_mode++;
                if (usr_mode !== op || usr_datain !== edin) side_ok = 1'b0;
            end else if (usr_datain !== 4'h0) begin
                side_ok = 1'b0;
            end
            if (busy === 1'b1) n_busy++;
            if (rsp_k > 0 && k == rsp_k + 1) begin
                valid_after = rsp_valid;
                break;
            end
            if (rsp_valid === 1'b1 && rsp_k < 0) begin
                rsp_k = k;
                rsp_d = rsp_data;
                ready_at_rsp = cmd_ready;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with no summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc_at;
        int         seen;
        logic [3:0] acc_dat;
        logic       er, ev;

        vt[0]  = '{MODE_LOAD, 4'b1011, 1'b0, 3'd0, 1, 4'b1011};
        vt[1]  = '{MODE_SHR,  4'b0000, 1'b1, 3'd2, 2, 4'b1110};
        vt[2]  = '{MODE_LOAD, 4'b1011, 1'b1, 3'd6, 1, 4'b1011};
        vt[3]  = '{MODE_SHL,  4'b1111, 1'b0, 3'd3, 3, 4'b1000};
        vt[4]  = '{MODE_SHR,  4'b0110, 1'b1, 3'd0, 0, 4'b1000};
        vt[5]  = '{MODE_HOLD, 4'b1111, 1'b1, 3'd5, 0, 4'b1000};
        vt[6]  = '{MODE_SHL,  4'b0000, 1'b1, 3'd7, 7, 4'b1111};
        vt[7]  = '{MODE_LOAD, 4'b0101, 1'b0, 3'd5, 1, 4'b0101};
        vt[8]  = '{MODE_SHR,  4'b1111, 1'b0, 3'd1, 1, 4'b0010};
        vt[9]  = '{MODE_SHL,  4'b0000, 1'b1, 3'd2, 2, 4'b1011};
        vt[10] = '{MODE_HOLD, 4'b0000, 1'b0, 3'd0, 0, 4'b1011};

        // Reset values, observed while reset is still held.
        @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_usr_mode", usr_mode, 0);
        chk("rst_usr_datain", usr_datain, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            run_cmd(vt[i].op, vt[i].data, vt[i].fill, vt[i].cnt);
            chk($sformatf("v%0d_rsp_latency", i), rsp_k, vt[i].n + 2);
            chk($sformatf("v%0d_rsp_data", i), rsp_d, vt[i].rsp);
            chk($sformatf("v%0d_mode_cycles", i), n_mode, vt[i].n);
            chk($sformatf("v%0d_busy_cycles", i), n_busy, vt[i].n + 1);
            chk($sformatf("v%0d_mode_datain", i), side_ok, 1);
            chk($sformatf("v%0d_rsp_one_cycle", i), valid_after, 0);
            chk($sformatf("v%0d_ready_at_rsp", i), ready_at_rsp, 1);
            if (i == 1) begin
                chk("shr_trace1", tr[2], 4'b1101);
                chk("shr_trace2", tr[3], 4'b1110);
            end
            if (i == 3) begin
                chk("shl_trace1", tr[2], 4'b0110);
                chk("shl_trace2", tr[3], 4'b1100);
                chk("shl_trace3", tr[4], 4'b1000);
            end
        end

        // cmd_valid held high with alternating LOAD words: only IDLE-cycle commands run.
        acc_at = -100;
        acc_dat = 4'h0;
        cmd_op = MODE_LOAD;
        cmd_valid = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cmd_data = j[0] ? 4'b0010 : 4'b0001;
            er = (j >= acc_at + 3);
            ev = (acc_at >= 0 && j == acc_at + 3);
            chk($sformatf("b2b%0d_ready", j), cmd_ready, er);
            chk($sformatf("b2b%0d_rsp_valid", j), rsp_valid, ev);
            if (ev) chk($sformatf("b2b%0d_rsp_data", j), rsp_data, acc_dat);
            chk($sformatf("b2b%0d_mode", j), usr_mode,
                (acc_at >= 0 && j == acc_at + 1) ? 3 : 0);
            if (er) begin
                acc_at = j;
                acc_dat = cmd_data;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("b2b_last_rsp_valid", rsp_valid, 1);
        chk("b2b_last_rsp_data", rsp_data, acc_dat);
        @(negedge clock);

        // Reset in the second cycle of a 5-step SHL discards the command.
        cmd_op = MODE_SHL; cmd_data = 4'h0; cmd_fill = 1'b1; cmd_count = 3'd5; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("mid_mode_before_reset", usr_mode, MODE_SHL);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_mode", usr_mode, 0);
        chk("mid_rst_datain", usr_datain, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        reset = 1'b0;
        seen = 0;
        for (int j = 0; j < 8; j++) begin
            if (rsp_valid !== 1'b0 || usr_mode !== MODE_HOLD) seen++;
            @(negedge clock);
        end
        chk("mid_rst_quiet", seen, 0);
        run_cmd(MODE_HOLD, 4'hF, 1'b1, 3'd7);
        chk("post_rst_read_latency", rsp_k, 2);
        chk("post_rst_read_data", rsp_d, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
